// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Shares one WIDTH-bit 4:1 multiplexer among four producers (a, b, c, d).
// Access is granted round-robin, but once a producer wins it may keep the
// mux for up to MAX_BURST consecutive beats before the grant rotates. The
// selected word is captured into a single-entry valid/ready output register
// that feeds one downstream consumer.
//
// Arbitration index of each producer: a=0, b=1, c=2, d=3.
// Physical mux select {s1,s0}:         a=00, b=10, c=01, d=11.
// The select is therefore the arbitration index with its two bits swapped.
//
// Ports
//   clk                                  clock, all state on the rising edge
//   rst                                  synchronous active-high reset
//   a, b, c, d            [WIDTH-1:0]    producer data words
//   a_valid .. d_valid                   producer holds a valid word
//   a_ready .. d_ready                   producer word taken this cycle
//   s0, s1                               mux select currently applied
//   y                     [WIDTH-1:0]    registered selected word
//   y_valid                              y holds a word
//   y_ready                              consumer takes y this cycle
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             a_valid,
    input  logic             b_valid,
    input  logic             c_valid,
    input  logic             d_valid,
    output logic             a_ready,
    output logic             b_ready,
    output logic             c_ready,
    output logic             d_ready,
    output logic             s0,
    output logic             s1,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       last_idx;
    logic [1:0]       last_nxt;
    logic [1:0]       owner_idx;
    logic [1:0]       owner_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [3:0]       req;
    logic             any_valid;
    logic             keep_owner;
    logic [1:0]       scan_start;
    logic [1:0]       scan_hit;
    logic             scan_found;
    logic [1:0]       grant_idx;
    logic [1:0]       sel_now;
    logic [1:0]       sel_q;
    logic [1:0]       sel_applied;
    logic             ld;
    logic             transfer;
    logic [3:0]       ready_vec;
    logic [WIDTH-1:0] mux_out;

    assign req       = {d_valid, c_valid, b_valid, a_valid};
    assign any_valid = |req;

    // The output register can take a new word when it is empty or when the
    // consumer is draining it in this same cycle.
    assign ld       = !y_valid || y_ready;
    assign transfer = ld && any_valid;

    // The current owner keeps the mux while it still has data and has not
    // used up its burst allowance.
    assign keep_owner = (state == BURST) && req[owner_idx] && (cnt < CNT_MAX);

    // Rotation starts just after the previous winner. Inside a burst the
    // owner and the last winner are the same source, but the owner is the
    // reference the burst-exit rotation is defined against.
    assign scan_start = (state == BURST) ? owner_idx + 2'd1 : last_idx + 2'd1;

    // Priority scan from scan_start upward with wrap. The loop runs from the
    // farthest offset down to the nearest so the nearest valid source is the
    // final assignment and wins. The reference source itself sits at offset
    // 3, which is why a lone owner is found again only after everyone else.
    always_comb begin
        scan_found = 1'b0;
        scan_hit   = scan_start;
        for (int i = 3; i >= 0; i--) begin
            if (req[scan_start + 2'(i)]) begin
                scan_found = 1'b1;
                scan_hit   = scan_start + 2'(i);
            end
        end
    end

    assign grant_idx = keep_owner ? owner_idx : scan_hit;

    // Index-to-select translation: swapping the index bits reproduces the
    // fixed mux wiring (b and c are not in binary order on the mux).
    assign sel_now = {grant_idx[0], grant_idx[1]};

    // With nobody requesting, the select lines park on whatever was last
    // applied instead of drifting to the scan's default position.
    assign sel_applied = (keep_owner || scan_found) ? sel_now : sel_q;
    assign s1          = sel_applied[1];
    assign s0          = sel_applied[0];

    // The shared 4:1 mux itself, addressed by the physical select code.
    always_comb begin
        mux_out = a;
        case (sel_now)
            2'b00:   mux_out = a;
            2'b01:   mux_out = c;
            2'b10:   mux_out = b;
            2'b11:   mux_out = d;
            default: mux_out = a;
        endcase
    end

    // Only the granted source sees ready, and only in a cycle where its word
    // is really captured. Nothing is acknowledged while reset is held.
    assign ready_vec = (transfer && !rst) ? (4'b0001 << grant_idx) : 4'b0000;
    assign a_ready   = ready_vec[0];
    assign b_ready   = ready_vec[1];
    assign c_ready   = ready_vec[2];
    assign d_ready   = ready_vec[3];

    // Next-state logic for the arbitration state. A beat from the current
    // owner extends the burst; any other beat starts a fresh burst for the
    // new winner. When the output can load but nobody offers data, the burst
    // ends and the next winner comes from a plain rotation after last_idx.
    // When the output is stalled everything holds.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner_idx;
        last_nxt  = last_idx;
        cnt_nxt   = cnt;
        if (transfer) begin
            state_nxt = BURST;
            if (keep_owner) begin
                cnt_nxt = cnt + CNT_ONE;
            end else begin
                owner_nxt = grant_idx;
                last_nxt  = grant_idx;
                cnt_nxt   = CNT_ONE;
            end
        end else if (ld) begin
            state_nxt = IDLE;
        end
    end

    // State register plus the output stage. Reset empties the output slot
    // and primes last_idx to d so that the first rotation lands on a.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_idx  <= 2'd3;
            owner_idx <= 2'd0;
            cnt       <= '0;
            sel_q     <= 2'b00;
            y         <= '0;
            y_valid   <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_idx  <= last_nxt;
            owner_idx <= owner_nxt;
            cnt       <= cnt_nxt;
            if (any_valid) begin
                sel_q <= sel_now;
            end
            if (transfer) begin
                y       <= mux_out;
                y_valid <= 1'b1;
            end else if (ld) begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule
